bp_be_mem_align: RTL and testbench
==================================

BP_BE_MEM_ALIGN -- requirements
Module: bp_be_mem_align

Interface
REQ-001 SHALL have parameter vaddr_width_p, default 39, the virtual address width.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_i, input, 1; one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports cmd_v_i (in, 1) and cmd_ready_o (out, 1): the ready/valid command handshake from the mem pipe.
REQ-005 SHALL have port cmd_op_i, input, 4, the memory op: lb=0, lh=1, lw=2, ld=3, lbu=4, lhu=5, lwu=6, sb=8, sh=9, sw=10, sd=11; all other codes are illegal.
REQ-006 SHALL have ports cmd_vaddr_i (in, vaddr_width_p) and cmd_data_i (in, 64): the effective address and the store data.
REQ-007 SHALL have ports dc_req_v_o (out, 1), dc_req_ready_i (in, 1), dc_we_o (out, 1), dc_addr_o (out, vaddr_width_p), dc_wdata_o (out, 64) and dc_wmask_o (out, 8): the dcache request.
REQ-008 SHALL have ports dc_resp_v_i (in, 1) and dc_rdata_i (in, 64): the dcache load data for the aligned doubleword.
REQ-009 SHALL have ports resp_v_o (out, 1), resp_data_o (out, 64), resp_exc_o (out, 2; bit0 = load misaligned, bit1 = store misaligned) and resp_badaddr_o (out, vaddr_width_p).
REQ-010 SHALL have port kill_i, input, 1, which flushes the operation in flight.

Function
REQ-011 SHALL implement a state machine with the states IDLE, REQ, WAIT and RESP, allowing one operation in flight.
REQ-012 SHALL drive cmd_ready_o = (state==IDLE) & ~kill_i.
REQ-013 SHALL, on an accepted command, register op, vaddr and data.
- Misaligned (h: addr[0]!=0; w: addr[1:0]!=0; d: addr[2:0]!=0) -> RESP with the exception bit set and badaddr = vaddr, and no dcache request is issued.
- Otherwise -> REQ.
REQ-014 SHALL, for an illegal op code, treat the op as lb/sb per bit3 and flag no exception.
REQ-015 SHALL, in REQ, drive dc_req_v_o=1 with the following fields, and hold all of them stable until dc_req_ready_i=1:
- dc_addr_o = {vaddr[msb:3], 3'b000}.
- dc_we_o = op[3].
- dc_wmask_o = size mask (b: 0x01, h: 0x03, w: 0x0F, d: 0xFF) shifted left by vaddr[2:0].
- dc_wdata_o = store data replicated across lanes for the size.
REQ-016 SHALL, on REQ handshake, go to RESP for a store and to WAIT for a load.
REQ-017 SHALL, in WAIT with dc_resp_v_i=1, select the lane at vaddr[2:0], sign-extend (lb/lh/lw) or zero-extend (lbu/lhu/lwu/ld) it to 64 bits, register the result, and go to RESP.
REQ-018 SHALL, in RESP, drive resp_v_o=1 for exactly one cycle and then return to IDLE.
- Stores: resp_data_o = 0.
- Exceptions: resp_data_o = 0.
- resp_exc_o and resp_badaddr_o are nonzero only on an exception response.
REQ-019 SHALL keep every output registered or state-decoded, with no combinational path from cmd_* to dc_* or resp_*.
REQ-020 SHALL meet the minimum latencies, where cycle 0 is the acceptance cycle:
- Aligned load: dc_req_v_o in cycle 1, dc_resp_v_i earliest in cycle 2, resp_v_o in cycle 3.
- Store: resp_v_o in cycle 2.
- Misaligned op: resp_v_o in cycle 1.
REQ-021 SHALL, when kill_i=1 in any state, go to IDLE next cycle and suppress resp_v_o in that same cycle and all later cycles for the killed op.
REQ-022 SHALL, on kill_i during REQ, drop dc_req_v_o next cycle even if it was not yet accepted; a store already handshaken stays committed.
REQ-023 SHALL ignore dc_resp_v_i in IDLE, REQ and RESP, including a late response for a killed load.
REQ-024 SHALL give kill_i priority over a simultaneous dc_resp_v_i or dc_req_ready_i.

Reset
REQ-025 SHALL, while reset_i=0 at a rising edge:
- Set state to IDLE.
- Drive cmd_ready_o=0, dc_req_v_o=0 and resp_v_o=0.
- Clear resp_data_o, resp_exc_o, resp_badaddr_o, dc_addr_o, dc_wdata_o and dc_wmask_o to 0.
REQ-026 SHALL, on reset asserted mid-operation, abandon the operation without a response, and SHALL accept a command in the first cycle after reset_i returns to 1.

Verification
REQ-027 SHALL cover: lb at vaddr 0x1005, dc_rdata_i=0x0000_8000_0000_0000 -> dc_addr_o=0x1000, resp_data_o=0xFFFF_FFFF_FFFF_FF80, resp_v_o in cycle 3.
REQ-028 SHALL cover: sh at 0x2006, data 0xABCD, ready held low 2 cycles -> dc_wmask_o=0xC0, dc_wdata_o lanes 6-7 = 0xABCD, request stable across the stall, resp_v_o one cycle after the handshake.
REQ-029 SHALL cover: lw at 0x3002 -> resp_v_o in cycle 1, resp_exc_o=2'b01, resp_badaddr_o=0x3002, dc_req_v_o never asserted.
REQ-030 SHALL cover: ld at 0x4000, kill_i in WAIT, then dc_resp_v_i 1 cycle later -> no resp_v_o; the next command is accepted the cycle after kill.
REQ-031 SHALL cover: lwu at 0x5004, rdata 0x8765_4321_0000_0000 -> resp_data_o=0x0000_0000_8765_4321.
REQ-032 SHALL cover: reset_i=0 asserted in WAIT -> all outputs 0 next cycle; a fresh sd after release completes normally.

Source files
------------

// File: rtl/bp_be_mem_align.sv
// Load/store alignment stage between the mem pipe and the dcache.
// Handles one operation at a time: misalignment check, lane masking and store replication, and load extraction.
module bp_be_mem_align #(
    parameter int vaddr_width_p = 39
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cmd_v_i,
    output logic                     cmd_ready_o,
    input  logic [3:0]               cmd_op_i,
    input  logic [vaddr_width_p-1:0] cmd_vaddr_i,
    input  logic [63:0]              cmd_data_i,
    output logic                     dc_req_v_o,
    input  logic                     dc_req_ready_i,
    output logic                     dc_we_o,
    output logic [vaddr_width_p-1:0] dc_addr_o,
    output logic [63:0]              dc_wdata_o,
    output logic [7:0]               dc_wmask_o,
    input  logic                     dc_resp_v_i,
    input  logic [63:0]              dc_rdata_i,
    output logic                     resp_v_o,
    output logic [63:0]              resp_data_o,
    output logic [1:0]               resp_exc_o,
    output logic [vaddr_width_p-1:0] resp_badaddr_o,
    input  logic                     kill_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                   state_r, state_n;
    logic [3:0]               op_r;
    logic [2:0]               offset_r;
    logic [63:0]              resp_data_r;
    logic [1:0]               exc_r;
    logic [vaddr_width_p-1:0] badaddr_r;
    logic [vaddr_width_p-1:0] dc_addr_r;
    logic [63:0]              dc_wdata_r;
    logic [7:0]               dc_wmask_r;

    logic                     accept;
    logic                     cmd_illegal;
    logic [3:0]               cmd_op_eff;
    logic                     cmd_misaligned;
    logic [7:0]               cmd_mask_base;
    logic [63:0]              cmd_wdata;
    logic [63:0]              rdata_shifted;
    logic [63:0]              load_data;

    assign cmd_ready_o = reset_i & (state_r == IDLE) & ~kill_i;
    assign accept      = cmd_v_i & cmd_ready_o;

    // Illegal codes collapse to a byte access so they can never fault on alignment.
    assign cmd_illegal = (cmd_op_i == 4'd7) | (cmd_op_i[3] & cmd_op_i[2]);
    assign cmd_op_eff  = cmd_illegal ? {cmd_op_i[3], 3'b000} : cmd_op_i;

    always_comb begin
        cmd_misaligned = 1'b0;
        cmd_mask_base  = 8'h01;
        cmd_wdata      = {8{cmd_data_i[7:0]}};
        case (cmd_op_eff[1:0])
            2'd1: begin
                cmd_misaligned = cmd_vaddr_i[0];
                cmd_mask_base  = 8'h03;
                cmd_wdata      = {4{cmd_data_i[15:0]}};
            end
            2'd2: begin
                cmd_misaligned = |cmd_vaddr_i[1:0];
                cmd_mask_base  = 8'h0F;
                cmd_wdata      = {2{cmd_data_i[31:0]}};
            end
            2'd3: begin
                cmd_misaligned = |cmd_vaddr_i[2:0];
                cmd_mask_base  = 8'hFF;
                cmd_wdata      = cmd_data_i;
            end
            default: ;
        endcase
    end

    assign rdata_shifted = dc_rdata_i >> {offset_r, 3'b000};

    // op_r[2] marks the unsigned load variants; ld is full width so needs no extension.
    always_comb begin
        load_data = rdata_shifted;
        case (op_r[1:0])
            2'd0: load_data = op_r[2] ? {56'd0, rdata_shifted[7:0]}
                                      : {{56{rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'd1: load_data = op_r[2] ? {48'd0, rdata_shifted[15:0]}
                                      : {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
            2'd2: load_data = op_r[2] ? {32'd0, rdata_shifted[31:0]}
                                      : {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: if (accept) state_n = cmd_misaligned ? RESP : REQ;
            REQ:  if (dc_req_ready_i) state_n = op_r[3] ? RESP : WAIT;
            WAIT: if (dc_resp_v_i) state_n = RESP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill_i) state_n = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_r     <= IDLE;
            op_r        <= '0;
            offset_r    <= '0;
            resp_data_r <= '0;
            exc_r       <= '0;
            badaddr_r   <= '0;
            dc_addr_r   <= '0;
            dc_wdata_r  <= '0;
            dc_wmask_r  <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                op_r        <= cmd_op_eff;
                offset_r    <= cmd_vaddr_i[2:0];
                dc_addr_r   <= {cmd_vaddr_i[vaddr_width_p-1:3], 3'b000};
                dc_wdata_r  <= cmd_wdata;
                dc_wmask_r  <= cmd_mask_base << cmd_vaddr_i[2:0];
                resp_data_r <= '0;
                exc_r       <= cmd_misaligned ? (cmd_op_eff[3] ? 2'b10 : 2'b01) : 2'b00;
                badaddr_r   <= cmd_misaligned ? cmd_vaddr_i : '0;
            end
            if ((state_r == WAIT) && dc_resp_v_i && !kill_i) begin
                resp_data_r <= load_data;
            end
        end
    end

    assign dc_req_v_o     = (state_r == REQ);
    assign dc_we_o        = dc_req_v_o & op_r[3];
    assign dc_addr_o      = dc_addr_r;
    assign dc_wdata_o     = dc_wdata_r;
    assign dc_wmask_o     = dc_wmask_r;

    // Response fields read as zero outside the single response cycle.
    assign resp_v_o       = (state_r == RESP) & ~kill_i;
    assign resp_data_o    = resp_v_o ? resp_data_r : '0;
    assign resp_exc_o     = resp_v_o ? exc_r : '0;
    assign resp_badaddr_o = resp_v_o ? badaddr_r : '0;

endmodule

// File: tb/tb_bp_be_mem_align.sv
// Directed self-checking bench for bp_be_mem_align: vector table plus hand-written kill/stall/reset sequences.
`timescale 1ns/1ps
module tb_bp_be_mem_align;

    localparam int VW = 39;

    logic          clk;
    logic          reset_i;
    logic          cmd_v_i;
    logic          cmd_ready_o;
    logic [3:0]    cmd_op_i;
    logic [VW-1:0] cmd_vaddr_i;
    logic [63:0]   cmd_data_i;
    logic          dc_req_v_o;
    logic          dc_req_ready_i;
    logic          dc_we_o;
    logic [VW-1:0] dc_addr_o;
    logic [63:0]   dc_wdata_o;
    logic [7:0]    dc_wmask_o;
    logic          dc_resp_v_i;
    logic [63:0]   dc_rdata_i;
    logic          resp_v_o;
    logic [63:0]   resp_data_o;
    logic [1:0]    resp_exc_o;
    logic [VW-1:0] resp_badaddr_o;
    logic          kill_i;

    int compared   = 0;
    int mismatched = 0;

    bp_be_mem_align #(.vaddr_width_p(VW)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .cmd_v_i        (cmd_v_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_op_i       (cmd_op_i),
        .cmd_vaddr_i    (cmd_vaddr_i),
        .cmd_data_i     (cmd_data_i),
        .dc_req_v_o     (dc_req_v_o),
        .dc_req_ready_i (dc_req_ready_i),
        .dc_we_o        (dc_we_o),
        .dc_addr_o      (dc_addr_o),
        .dc_wdata_o     (dc_wdata_o),
        .dc_wmask_o     (dc_wmask_o),
        .dc_resp_v_i    (dc_resp_v_i),
        .dc_rdata_i     (dc_rdata_i),
        .resp_v_o       (resp_v_o),
        .resp_data_o    (resp_data_o),
        .resp_exc_o     (resp_exc_o),
        .resp_badaddr_o (resp_badaddr_o),
        .kill_i         (kill_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    op;
        logic [VW-1:0] vaddr;
        logic [63:0]   data;
        logic [63:0]   rdata;
        logic          exp_req;
        logic [VW-1:0] exp_addr;
        logic [7:0]    exp_mask;
        logic [63:0]   exp_wdata;
        logic          exp_we;
        logic [63:0]   exp_out;
        logic [1:0]    exp_exc;
        logic [VW-1:0] exp_bad;
        int            exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int  lat;
        bit  saw_req;
        nextCycle();
        cmd_v_i        = 1'b1;
        cmd_op_i       = v.op;
        cmd_vaddr_i    = v.vaddr;
        cmd_data_i     = v.data;
        dc_req_ready_i = 1'b1;
        dc_resp_v_i    = 1'b1;
        dc_rdata_i     = v.rdata;
        #1;
        checkOutput($sformatf("v%0d_cmd_ready", idx), 64'(cmd_ready_o), 64'd1);
        lat     = -1;
        saw_req = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            nextCycle();
            cmd_v_i = 1'b0;
            #1;
            if (dc_req_v_o && !saw_req) begin
                saw_req = 1'b1;
                checkOutput($sformatf("v%0d_dc_addr", idx), 64'(dc_addr_o), 64'(v.exp_addr));
                checkOutput($sformatf("v%0d_dc_wmask", idx), 64'(dc_wmask_o), 64'(v.exp_mask));
                checkOutput($sformatf("v%0d_dc_wdata", idx), dc_wdata_o, v.exp_wdata);
                checkOutput($sformatf("v%0d_dc_we", idx), 64'(dc_we_o), 64'(v.exp_we));
            end
            if (resp_v_o) begin
                lat = cyc;
                checkOutput($sformatf("v%0d_resp_data", idx), resp_data_o, v.exp_out);
                checkOutput($sformatf("v%0d_resp_exc", idx), 64'(resp_exc_o), 64'(v.exp_exc));
                checkOutput($sformatf("v%0d_resp_bad", idx), 64'(resp_badaddr_o), 64'(v.exp_bad));
                break;
            end
        end
        checkOutput($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
        checkOutput($sformatf("v%0d_req_seen", idx), 64'(saw_req), 64'(v.exp_req));
        nextCycle();
        dc_resp_v_i = 1'b0;
        #1;
        checkOutput($sformatf("v%0d_resp_one_shot", idx), 64'(resp_v_o), 64'd0);
    endtask

    initial begin
        //            op     vaddr       data                    rdata                   req  addr        mask   wdata                   we   out                     exc    bad         lat
        vecs[0]  = '{4'd0,  39'h1005, 64'h0,                  64'h0000_8000_0000_0000, 1'b1, 39'h1000, 8'h20, 64'h0,                  1'b0, 64'hFFFF_FFFF_FFFF_FF80, 2'b00, 39'h0,    3};
        vecs[1]  = '{4'd6,  39'h5004, 64'h0,                  64'h8765_4321_0000_0000, 1'b1, 39'h5000, 8'hF0, 64'h0,                  1'b0, 64'h0000_0000_8765_4321, 2'b00, 39'h0,    3};
        vecs[2]  = '{4'd2,  39'h3002, 64'h0,                  64'h0,                   1'b0, 39'h0,    8'h00, 64'h0,                  1'b0, 64'h0,                   2'b01, 39'h3002, 1};
        vecs[3]  = '{4'd8,  39'h6003, 64'h1234_5678_9ABC_DEF0, 64'h0,                  1'b1, 39'h6000, 8'h08, 64'hF0F0_F0F0_F0F0_F0F0, 1'b1, 64'h0,                   2'b00, 39'h0,    2};
        vecs[4]  = '{4'd10, 39'h7004, 64'h1111_2222_3333_4444, 64'h0,                  1'b1, 39'h7000, 8'hF0, 64'h3333_4444_3333_4444, 1'b1, 64'h0,                   2'b00, 39'h0,    2};
        vecs[5]  = '{4'd11, 39'h8001, 64'h0,                  64'h0,                   1'b0, 39'h0,    8'h00, 64'h0,                  1'b0, 64'h0,                   2'b10, 39'h8001, 1};
        vecs[6]  = '{4'd1,  39'h9006, 64'h0,                  64'h8001_0000_0000_0000, 1'b1, 39'h9000, 8'hC0, 64'h0,                  1'b0, 64'hFFFF_FFFF_FFFF_8001, 2'b00, 39'h0,    3};
        vecs[7]  = '{4'd5,  39'h9002, 64'h0,                  64'h0000_0000_F00D_0000, 1'b1, 39'h9000, 8'h0C, 64'h0,                  1'b0, 64'h0000_0000_0000_F00D, 2'b00, 39'h0,    3};
        vecs[8]  = '{4'd3,  39'hA000, 64'h0,                  64'hDEAD_BEEF_CAFE_F00D, 1'b1, 39'hA000, 8'hFF, 64'h0,                  1'b0, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 39'h0,    3};
        vecs[9]  = '{4'd4,  39'hB007, 64'h0,                  64'hFE00_0000_0000_0000, 1'b1, 39'hB000, 8'h80, 64'h0,                  1'b0, 64'h0000_0000_0000_00FE, 2'b00, 39'h0,    3};
        vecs[10] = '{4'd7,  39'hC003, 64'h0,                  64'h0000_0000_8100_0000, 1'b1, 39'hC000, 8'h08, 64'h0,                  1'b0, 64'hFFFF_FFFF_FFFF_FF81, 2'b00, 39'h0,    3};
        vecs[11] = '{4'd13, 39'hC005, 64'h55AA,               64'h0,                   1'b1, 39'hC000, 8'h20, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'h0,                   2'b00, 39'h0,    2};
        vecs[12] = '{4'd2,  39'hD004, 64'h0,                  64'h7FFF_FFFF_0000_0000, 1'b1, 39'hD000, 8'hF0, 64'h0,                  1'b0, 64'h0000_0000_7FFF_FFFF, 2'b00, 39'h0,    3};
        vecs[13] = '{4'd9,  39'hE001, 64'h0,                  64'h0,                   1'b0, 39'h0,    8'h00, 64'h0,                  1'b0, 64'h0,                   2'b10, 39'hE001, 1};

        reset_i        = 1'b0;
        cmd_v_i        = 1'b0;
        cmd_op_i       = 4'd0;
        cmd_vaddr_i    = '0;
        cmd_data_i     = '0;
        dc_req_ready_i = 1'b0;
        dc_resp_v_i    = 1'b0;
        dc_rdata_i     = '0;
        kill_i         = 1'b0;

        nextCycle();
        nextCycle();
        #1;
        checkOutput("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        checkOutput("rst_dc_req_v", 64'(dc_req_v_o), 64'd0);
        checkOutput("rst_resp_v", 64'(resp_v_o), 64'd0);
        checkOutput("rst_dc_addr", 64'(dc_addr_o), 64'd0);
        checkOutput("rst_dc_wmask", 64'(dc_wmask_o), 64'd0);
        checkOutput("rst_dc_wdata", dc_wdata_o, 64'd0);
        reset_i = 1'b1;

        for (int i = 0; i < 14; i++) applyStimulus(i, vecs[i]);

        // sh with a two-cycle dcache stall; a second command must not be taken meanwhile.
        nextCycle();
        cmd_v_i = 1'b1; cmd_op_i = 4'd9; cmd_vaddr_i = 39'h2006; cmd_data_i = 64'hABCD;
        dc_req_ready_i = 1'b0;
        #1;
        checkOutput("sh_accept", 64'(cmd_ready_o), 64'd1);
        for (int c = 1; c <= 3; c++) begin
            nextCycle();
            cmd_op_i = 4'd0; cmd_vaddr_i = 39'h9999;
            dc_req_ready_i = (c == 3);
            #1;
            checkOutput($sformatf("sh_c%0d_busy", c), 64'(cmd_ready_o), 64'd0);
            checkOutput($sformatf("sh_c%0d_req_v", c), 64'(dc_req_v_o), 64'd1);
            checkOutput($sformatf("sh_c%0d_we", c), 64'(dc_we_o), 64'd1);
            checkOutput($sformatf("sh_c%0d_addr", c), 64'(dc_addr_o), 64'h2000);
            checkOutput($sformatf("sh_c%0d_wmask", c), 64'(dc_wmask_o), 64'hC0);
            checkOutput($sformatf("sh_c%0d_wdata", c), dc_wdata_o, 64'hABCD_ABCD_ABCD_ABCD);
            checkOutput($sformatf("sh_c%0d_no_resp", c), 64'(resp_v_o), 64'd0);
        end
        nextCycle();
        cmd_v_i = 1'b0; dc_req_ready_i = 1'b0;
        #1;
        checkOutput("sh_resp_v", 64'(resp_v_o), 64'd1);
        checkOutput("sh_resp_data", resp_data_o, 64'd0);
        checkOutput("sh_req_dropped", 64'(dc_req_v_o), 64'd0);

        // ld killed in WAIT, late response ignored, next command accepted right after the kill.
        nextCycle();
        cmd_v_i = 1'b1; cmd_op_i = 4'd3; cmd_vaddr_i = 39'h4000; cmd_data_i = 64'h0;
        dc_req_ready_i = 1'b1; dc_resp_v_i = 1'b0;
        #1;
        checkOutput("kw_accept", 64'(cmd_ready_o), 64'd1);
        nextCycle();
        cmd_v_i = 1'b0;
        #1;
        checkOutput("kw_req_v", 64'(dc_req_v_o), 64'd1);
        nextCycle();
        kill_i = 1'b1;
        #1;
        checkOutput("kw_kill_no_resp", 64'(resp_v_o), 64'd0);
        checkOutput("kw_kill_not_ready", 64'(cmd_ready_o), 64'd0);
        nextCycle();
        kill_i = 1'b0; dc_resp_v_i = 1'b1; dc_rdata_i = 64'h1234_5678_9ABC_DEF0;
        cmd_v_i = 1'b1; cmd_op_i = 4'd8; cmd_vaddr_i = 39'h4100; cmd_data_i = 64'h77;
        #1;
        checkOutput("kw_late_no_resp", 64'(resp_v_o), 64'd0);
        checkOutput("kw_next_ready", 64'(cmd_ready_o), 64'd1);
        nextCycle();
        cmd_v_i = 1'b0;
        #1;
        checkOutput("kw_sb_req_v", 64'(dc_req_v_o), 64'd1);
        checkOutput("kw_sb_wmask", 64'(dc_wmask_o), 64'h01);
        checkOutput("kw_sb_wdata", dc_wdata_o, 64'h7777_7777_7777_7777);
        checkOutput("kw_sb_no_resp", 64'(resp_v_o), 64'd0);
        nextCycle();
        dc_resp_v_i = 1'b0;
        #1;
        checkOutput("kw_sb_resp_v", 64'(resp_v_o), 64'd1);
        checkOutput("kw_sb_resp_data", resp_data_o, 64'd0);

        // Kill in REQ wins over a simultaneous ready; request drops the next cycle.
        nextCycle();
        cmd_v_i = 1'b1; cmd_op_i = 4'd2; cmd_vaddr_i = 39'h4200; dc_req_ready_i = 1'b0;
        #1;
        nextCycle();
        cmd_v_i = 1'b0; kill_i = 1'b1; dc_req_ready_i = 1'b1;
        #1;
        checkOutput("kr_req_v_same_cycle", 64'(dc_req_v_o), 64'd1);
        nextCycle();
        kill_i = 1'b0;
        #1;
        checkOutput("kr_req_dropped", 64'(dc_req_v_o), 64'd0);
        checkOutput("kr_idle_ready", 64'(cmd_ready_o), 64'd1);
        checkOutput("kr_no_resp", 64'(resp_v_o), 64'd0);
        nextCycle();
        #1;
        checkOutput("kr_no_resp_later", 64'(resp_v_o), 64'd0);

        // Kill in RESP suppresses the misaligned response in the same cycle.
        nextCycle();
        cmd_v_i = 1'b1; cmd_op_i = 4'd1; cmd_vaddr_i = 39'h4301;
        #1;
        nextCycle();
        cmd_v_i = 1'b0; kill_i = 1'b1;
        #1;
        checkOutput("kp_resp_v", 64'(resp_v_o), 64'd0);
        checkOutput("kp_resp_exc", 64'(resp_exc_o), 64'd0);
        nextCycle();
        kill_i = 1'b0;
        #1;
        checkOutput("kp_after_resp_v", 64'(resp_v_o), 64'd0);
        checkOutput("kp_after_ready", 64'(cmd_ready_o), 64'd1);

        // Reset during WAIT clears everything; an sd right after release completes.
        nextCycle();
        cmd_v_i = 1'b1; cmd_op_i = 4'd3; cmd_vaddr_i = 39'h6000;
        dc_req_ready_i = 1'b1; dc_resp_v_i = 1'b0;
        #1;
        nextCycle();
        cmd_v_i = 1'b0;
        #1;
        nextCycle();
        reset_i = 1'b0;
        #1;
        nextCycle();
        #1;
        checkOutput("rw_cmd_ready", 64'(cmd_ready_o), 64'd0);
        checkOutput("rw_dc_req_v", 64'(dc_req_v_o), 64'd0);
        checkOutput("rw_dc_we", 64'(dc_we_o), 64'd0);
        checkOutput("rw_dc_addr", 64'(dc_addr_o), 64'd0);
        checkOutput("rw_dc_wmask", 64'(dc_wmask_o), 64'd0);
        checkOutput("rw_dc_wdata", dc_wdata_o, 64'd0);
        checkOutput("rw_resp_v", 64'(resp_v_o), 64'd0);
        checkOutput("rw_resp_data", resp_data_o, 64'd0);
        checkOutput("rw_resp_exc", 64'(resp_exc_o), 64'd0);
        checkOutput("rw_resp_bad", 64'(resp_badaddr_o), 64'd0);
        nextCycle();
        reset_i = 1'b1;
        cmd_v_i = 1'b1; cmd_op_i = 4'd11; cmd_vaddr_i = 39'h6008; cmd_data_i = 64'h0123_4567_89AB_CDEF;
        dc_resp_v_i = 1'b1;
        #1;
        checkOutput("rw_release_ready", 64'(cmd_ready_o), 64'd1);
        nextCycle();
        cmd_v_i = 1'b0;
        #1;
        checkOutput("rw_sd_req_v", 64'(dc_req_v_o), 64'd1);
        checkOutput("rw_sd_addr", 64'(dc_addr_o), 64'h6008);
        checkOutput("rw_sd_wmask", 64'(dc_wmask_o), 64'hFF);
        checkOutput("rw_sd_wdata", dc_wdata_o, 64'h0123_4567_89AB_CDEF);
        checkOutput("rw_sd_no_resp", 64'(resp_v_o), 64'd0);
        nextCycle();
        dc_resp_v_i = 1'b0;
        #1;
        checkOutput("rw_sd_resp_v", 64'(resp_v_o), 64'd1);
        checkOutput("rw_sd_resp_data", resp_data_o, 64'd0);
        checkOutput("rw_sd_resp_exc", 64'(resp_exc_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
